// File: rtl/lsu.sv
// RV32I load/store unit: byte/halfword stores are done as a read-modify-write of the containing word.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W requests; otherwise they are force-aligned.
module lsu #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_is_load,
    output logic        dm_is_store,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_store_data,
    input  logic [31:0] dm_load_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        reject;
    logic [31:0] addr_aligned;
    logic        is_sw;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [31:0] byte_src;
    logic [31:0] half_src;
    logic        unused_addr;

    assign unused_addr = &{1'b0, addr_q[31:ADDR_WIDTH+2]};

    always_comb begin
        reject       = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        addr_aligned = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00))
            reject = 1'b1;
`else
        if (req_funct3[1:0] == 2'b01)
            addr_aligned[0] = 1'b0;
        else if (req_funct3[1:0] == 2'b10)
            addr_aligned[1:0] = 2'b00;
`endif
    end

    // Lane extraction for loads and lane replacement for sub-word stores share the latched offset.
    always_comb begin
        is_sw    = we_q && (f3_q[1:0] == 2'b10);
        byte_src = dm_load_data >> {addr_q[1:0], 3'b000};
        half_src = dm_load_data >> {addr_q[1], 4'b0000};
        case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {24'b0, byte_src[7:0]}
                                        : {{24{byte_src[7]}}, byte_src[7:0]};
            2'b01:   load_ext = f3_q[2] ? {16'b0, half_src[15:0]}
                                        : {{16{half_src[15]}}, half_src[15:0]};
            default: load_ext = dm_load_data;
        endcase
        merged = dm_load_data;
        if (f3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            merged_q <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= addr_aligned;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'b0;
                        err_q   <= reject;
                        state   <= reject ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (we_q && !is_sw) begin
                        merged_q <= merged;
                        state    <= S_WRITE;
                    end else begin
                        rdata_q <= we_q ? 32'b0 : load_ext;
                        state   <= S_RESP;
                    end
                end
                S_WRITE: state <= S_RESP;
                default: begin
                    if (resp_ready) begin
                        rdata_q <= 32'b0;
                        err_q   <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Reset gates the store strobe directly so an in-flight WRITE never commits.
    always_comb begin
        req_ready     = (state == S_IDLE) && !rst;
        resp_valid    = (state == S_RESP);
        resp_rdata    = rdata_q;
        resp_err      = err_q;
        dm_is_load    = (state == S_ACCESS) && !is_sw;
        dm_is_store   = !rst && (((state == S_ACCESS) && is_sw) || (state == S_WRITE));
        dm_addr       = 32'b0;
        dm_store_data = 32'b0;
        if (state == S_ACCESS || state == S_WRITE)
            dm_addr = 32'(addr_q[ADDR_WIDTH+1:2]);
        if (state == S_ACCESS && is_sw)
            dm_store_data = wdata_q;
        else if (state == S_WRITE)
            dm_store_data = merged_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a word-addressed memory model and response scoreboard.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_is_load;
    logic        dm_is_store;
    logic [31:0] dm_addr;
    logic [31:0] dm_store_data;
    logic [31:0] dm_load_data;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mem[0:4095];
    logic        mem_loaded = 1'b0;
    int          load_cnt = 0;
    int          store_cnt = 0;
    logic [31:0] last_store = 32'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(12)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .dm_is_load(dm_is_load),
        .dm_is_store(dm_is_store),
        .dm_addr(dm_addr),
        .dm_store_data(dm_store_data),
        .dm_load_data(dm_load_data)
    );

    assign dm_load_data = mem[dm_addr[11:0]];

    // Memory model plus activity counters sampled at each rising edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'b0;
            mem[1]     <= 32'h8899AABB;
            mem_loaded <= 1'b1;
        end else if (dm_is_store) begin
            mem[dm_addr[11:0]] <= dm_store_data;
        end
        if (dm_is_load) load_cnt <= load_cnt + 1;
        if (dm_is_store) begin
            store_cnt  <= store_cnt + 1;
            last_store <= dm_store_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
        resp_t e;
        checkOutput("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata    = erd;
        e.err      = eerr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    task automatic waitResp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic popCompare(input string tag);
        resp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("%s_rdata", tag), resp_rdata, e.rdata);
            checkOutput($sformatf("%s_err", tag), {31'b0, resp_err}, {31'b0, e.err});
        end
    endtask

    task automatic doReq(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erd, input logic eerr,
                         input int elat, input int eloads, input int estores);
        int l0;
        int s0;
        int lat;
        l0 = load_cnt;
        s0 = store_cnt;
        applyStimulus(we, f3, addr, wdata, erd, eerr);
        waitResp(lat);
        checkOutput($sformatf("%s_latency", tag), 32'(lat), 32'(elat));
        popCompare(tag);
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s_resp_drop", tag), {31'b0, resp_valid}, 32'd0);
        checkOutput($sformatf("%s_loads", tag), 32'(load_cnt - l0), 32'(eloads));
        checkOutput($sformatf("%s_stores", tag), 32'(store_cnt - s0), 32'(estores));
    endtask

    initial begin
        int lat;
        int s0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_dm_is_load", {31'b0, dm_is_load}, 32'd0);
        checkOutput("rst_dm_is_store", {31'b0, dm_is_store}, 32'd0);
        checkOutput("rst_dm_addr", dm_addr, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        doReq("lw_4",   1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);
        doReq("lb_7",   1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0);
        doReq("lbu_7",  1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0, 2, 1, 0);
        doReq("lh_6",   1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
        doReq("lhu_4",  1'b0, 3'b101, 32'h4, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0);
        doReq("lb_4",   1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1, 0);

        doReq("sb_5",   1'b1, 3'b000, 32'h5, 32'h000000CC, 32'h0, 1'b0, 3, 1, 1);
        checkOutput("sb_5_store_data", last_store, 32'h8899CCBB);
        checkOutput("sb_5_mem", mem[1], 32'h8899CCBB);
        doReq("lw_after_sb", 1'b0, 3'b010, 32'h4, 32'h0, 32'h8899CCBB, 1'b0, 2, 1, 0);

        doReq("sw_8",   1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
        checkOutput("sw_8_mem", mem[2], 32'hDEADBEEF);
        doReq("sh_a",   1'b1, 3'b001, 32'hA, 32'h55551234, 32'h0, 1'b0, 3, 1, 1);
        checkOutput("sh_a_mem", mem[2], 32'h1234BEEF);

        doReq("f3_011", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        doReq("f3_111_st", 1'b1, 3'b111, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0);
        checkOutput("f3_111_mem", mem[2], 32'h1234BEEF);
        doReq("alias_lw", 1'b0, 3'b010, 32'h4004, 32'h0, 32'h8899CCBB, 1'b0, 2, 1, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        doReq("lw_6_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        doReq("lh_5_mis", 1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
        doReq("lw_6_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'h8899CCBB, 1'b0, 2, 1, 0);
        doReq("lh_5_mis", 1'b0, 3'b001, 32'h5, 32'h0, 32'hFFFFCCBB, 1'b0, 2, 1, 0);
`endif

        // Backpressure: response must hold steady while the consumer stalls.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 32'h1234BEEF, 1'b0);
        waitResp(lat);
        checkOutput("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            checkOutput("bp_resp_rdata", resp_rdata, 32'h1234BEEF);
            checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        popCompare("bp");
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_resume_ready", {31'b0, req_ready}, 32'd1);
        doReq("bp_next", 1'b0, 3'b101, 32'hA, 32'h0, 32'h00001234, 1'b0, 2, 1, 0);

        // Reset during WRITE of an SH must suppress the store.
        s0 = store_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h4;
        req_wdata  = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstw_dm_is_store", {31'b0, dm_is_store}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rstw_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rstw_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rstw_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rstw_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rstw_dm_is_load", {31'b0, dm_is_load}, 32'd0);
        checkOutput("rstw_dm_addr", dm_addr, 32'd0);
        checkOutput("rstw_dm_store_data", dm_store_data, 32'd0);
        checkOutput("rstw_stores", 32'(store_cnt - s0), 32'd0);
        checkOutput("rstw_mem", mem[1], 32'h8899CCBB);
        doReq("post_rstw_lw", 1'b0, 3'b010, 32'h4, 32'h0, 32'h8899CCBB, 1'b0, 2, 1, 0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
